alarm_ctrl: RTL and testbench

- Downstream consumer of the alarm-setting stage: takes the alarm time (a_hour, a_min) and the running clock time, and decides when the alarm sounds.
- Handles snooze and stop requests, ring timeout and the buzzer beep pattern.
- Drives the buzzer pin and the alarm status LED. Button inputs arrive as one-cycle pulses that are already edge-detected.

---
 rtl/alarm_ctrl_if.sv | 27 ++
 rtl/alarm_ctrl.sv | 112 +++++++++++
 tb/tb_alarm_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the time-keeping/alarm-setting stages and the alarm controller.
// The master side supplies time, buttons and enable. The slave side returns the buzzer and status outputs.
interface alarm_ctrl_if;
    logic       enb;
    logic       tick_1hz;
    logic [5:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic [5:0] a_hour;
    logic [5:0] a_min;
    logic       snooze_p;
    logic       stop_p;
    logic       buzz;
    logic       ringing;
    logic       snoozing;
    logic [1:0] snooze_cnt;

    modport master (
        output enb, tick_1hz, cur_hour, cur_min, cur_sec, a_hour, a_min, snooze_p, stop_p,
        input  buzz, ringing, snoozing, snooze_cnt
    );

    modport slave (
        input  enb, tick_1hz, cur_hour, cur_min, cur_sec, a_hour, a_min, snooze_p, stop_p,
        output buzz, ringing, snoozing, snooze_cnt
    );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm controller. It decides when the alarm rings, and it handles snooze, stop, ring timeout and the 1 s on / 1 s off beep.
module alarm_ctrl #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic         clk,
    input  logic         rst,
    alarm_ctrl_if.slave  alarm_io
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RINGING = 2'd1;
    localparam logic [1:0] SNOOZE  = 2'd2;

    localparam logic [5:0] RING_LIMIT = 6'(RING_SEC);
    localparam logic [9:0] SNOOZE_LEN = 10'(SNOOZE_MIN * 60);
    localparam logic [1:0] SNOOZE_MAX = 2'(MAX_SNOOZE);

    logic [1:0] state_q, state_d;
    logic [5:0] sec_cnt_q, sec_cnt_d;
    logic [9:0] rem_sec_q, rem_sec_d;
    logic       beep_q, beep_d;
    logic [1:0] snooze_cnt_q, snooze_cnt_d;
    logic       match;

    // Requiring the tick and second zero limits this to one firing per alarm minute.
    assign match = alarm_io.enb & alarm_io.tick_1hz &
                   (alarm_io.cur_hour == alarm_io.a_hour) &
                   (alarm_io.cur_min  == alarm_io.a_min) &
                   (alarm_io.cur_sec  == 6'd0);

    always_comb begin
        state_d      = state_q;
        sec_cnt_d    = sec_cnt_q;
        rem_sec_d    = rem_sec_q;
        beep_d       = beep_q;
        snooze_cnt_d = snooze_cnt_q;

        if (!alarm_io.enb) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (match) begin
                        state_d      = RINGING;
                        sec_cnt_d    = 6'd0;
                        snooze_cnt_d = 2'd0;
                        beep_d       = 1'b1;
                    end
                end
                RINGING: begin
                    if (alarm_io.stop_p) begin
                        state_d = IDLE;
                    end else if (alarm_io.snooze_p) begin
                        if (snooze_cnt_q < SNOOZE_MAX) begin
                            state_d      = SNOOZE;
                            snooze_cnt_d = snooze_cnt_q + 2'd1;
                            rem_sec_d    = SNOOZE_LEN;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (alarm_io.tick_1hz) begin
                        sec_cnt_d = sec_cnt_q + 6'd1;
                        beep_d    = ~beep_q;
                        if (sec_cnt_d == RING_LIMIT) begin
                            state_d = IDLE;
                        end
                    end
                end
                SNOOZE: begin
                    // Stop outranks the expiry tick. Snooze presses are meaningless here.
                    if (alarm_io.stop_p) begin
                        state_d = IDLE;
                    end else if (alarm_io.tick_1hz) begin
                        rem_sec_d = rem_sec_q - 10'd1;
                        if (rem_sec_q == 10'd1) begin
                            state_d   = RINGING;
                            sec_cnt_d = 6'd0;
                            beep_d    = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sec_cnt_q    <= 6'd0;
            rem_sec_q    <= 10'd0;
            beep_q       <= 1'b0;
            snooze_cnt_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            sec_cnt_q    <= sec_cnt_d;
            rem_sec_q    <= rem_sec_d;
            beep_q       <= beep_d;
            snooze_cnt_q <= snooze_cnt_d;
        end
    end

    assign alarm_io.buzz       = (state_q == RINGING) & beep_q;
    assign alarm_io.ringing    = (state_q == RINGING);
    assign alarm_io.snoozing   = (state_q == SNOOZE);
    assign alarm_io.snooze_cnt = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl. Stimulus queues the expected outputs.
// A negedge monitor pops each expectation and compares it after the following clock edge.
module tb_alarm_ctrl;

    typedef struct packed {
        logic       buzz;
        logic       ringing;
        logic       snoozing;
        logic [1:0] cnt;
    } expT;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [5:0] hourV;
    logic [5:0] minV;
    logic [5:0] secV;
    logic       enbV;

    expT   expQ[$];
    string nameQ[$];

    alarm_ctrl_if bus ();

    alarm_ctrl #(
        .RING_SEC  (60),
        .SNOOZE_MIN(5),
        .MAX_SNOOZE(3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .alarm_io(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input expT e);
        expT got;
        got = '{bus.buzz, bus.ringing, bus.snoozing, bus.snooze_cnt};
        checks++;
        if (got !== e) begin
            failures++;
            $display("[TB] FAIL %s: got buzz=%b ringing=%b snoozing=%b cnt=%0d, expected buzz=%b ringing=%b snoozing=%b cnt=%0d",
                     name, got.buzz, got.ringing, got.snoozing, got.cnt,
                     e.buzz, e.ringing, e.snoozing, e.cnt);
        end
    endtask

    // The monitor pops one expectation at each falling edge while the queue is not empty.
    initial begin
        expT   e;
        string n;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                n = nameQ.pop_front();
                checkOutput(n, e);
            end
        end
    end

    // Each call drives exactly one rising edge. The inputs are held until the next call.
    task automatic applyStimulus(input logic tick, input logic sn, input logic st, input bit chk,
                                 input string name, input logic eb, input logic er,
                                 input logic es, input logic [1:0] ec);
        @(negedge clk);
        #1;
        bus.enb      = enbV;
        bus.cur_hour = hourV;
        bus.cur_min  = minV;
        bus.cur_sec  = secV;
        bus.tick_1hz = tick;
        bus.snooze_p = sn;
        bus.stop_p   = st;
        if (chk) begin
            expQ.push_back('{eb, er, es, ec});
            nameQ.push_back(name);
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "", 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "", 1'b0, 1'b0, 1'b0, 2'd0);
            idleCycle();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        enbV     = 1'b1;
        hourV    = 6'd6;
        minV     = 6'd29;
        secV     = 6'd59;
        bus.enb      = 1'b1;
        bus.tick_1hz = 1'b0;
        bus.cur_hour = 6'd6;
        bus.cur_min  = 6'd29;
        bus.cur_sec  = 6'd59;
        bus.a_hour   = 6'd6;
        bus.a_min    = 6'd30;
        bus.snooze_p = 1'b0;
        bus.stop_p   = 1'b0;

        #12;
        checkOutput("resetState", '{1'b0, 1'b0, 1'b0, 2'd0});
        @(negedge clk);
        #1;
        rst = 1'b0;
        idleCycle();

        // Basic ring, beep pattern and timeout after 60 ticks.
        minV = 6'd30;
        secV = 6'd0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, "ringStart", 1'b1, 1'b1, 1'b0, 2'd0);
        idleCycle();
        secV = 6'd1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, "beep1", 1'b0, 1'b1, 1'b0, 2'd0);
        idleCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, "beep2", 1'b1, 1'b1, 1'b0, 2'd0);
        idleCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, "beep3", 1'b0, 1'b1, 1'b0, 2'd0);
        idleCycle();
        runTicks(55);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, "tick59", 1'b0, 1'b1, 1'b0, 2'd0);
        idleCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, "timeout", 1'b0, 1'b0, 1'b0, 2'd0);
        idleCycle();

        // Snooze once, wait for expiry, then stop.
        secV = 6'd0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, "ring2", 1'b1, 1'b1, 1'b0, 2'd0);
        idleCycle();
        secV = 6'd1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "snooze1", 1'b0, 1'b0, 1'b1, 2'd1);
        runTicks(298);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, "snz299", 1'b0, 1'b0, 1'b1, 2'd1);
        idleCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, "snzExpire", 1'b1, 1'b1, 1'b0, 2'd1);
        idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, "stopKeepsCnt", 1'b0, 1'b0, 1'b0, 2'd1);
        idleCycle();

        // Three snoozes, the fourth acts as stop. The next day's match clears the count.
        secV = 6'd0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, "ring3", 1'b1, 1'b1, 1'b0, 2'd0);
        idleCycle();
        secV = 6'd1;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, $sformatf("snooze%0d", i), 1'b0, 1'b0, 1'b1, 2'(i));
            runTicks(299);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, $sformatf("reRing%0d", i), 1'b1, 1'b1, 1'b0, 2'(i));
            idleCycle();
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "snoozeMax", 1'b0, 1'b0, 1'b0, 2'd3);
        idleCycle();
        secV = 6'd0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, "nextDay", 1'b1, 1'b1, 1'b0, 2'd0);
        idleCycle();
        secV = 6'd1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, "stopNextDay", 1'b0, 1'b0, 1'b0, 2'd0);
        idleCycle();

        // Enable handling, and a match that coincides with button pulses in IDLE.
        enbV = 1'b0;
        secV = 6'd0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, "enbOff", 1'b0, 1'b0, 1'b0, 2'd0);
        idleCycle();
        enbV = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, "matchWins", 1'b1, 1'b1, 1'b0, 2'd0);
        idleCycle();
        secV = 6'd1;
        enbV = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "dropRing", 1'b0, 1'b0, 1'b0, 2'd0);
        enbV = 1'b1;
        idleCycle();
        secV = 6'd0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, "ring4", 1'b1, 1'b1, 1'b0, 2'd0);
        idleCycle();
        secV = 6'd1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "snooze4", 1'b0, 1'b0, 1'b1, 2'd1);
        enbV = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "dropSnooze", 1'b0, 1'b0, 1'b0, 2'd1);
        enbV = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "idleButtons", 1'b0, 1'b0, 1'b0, 2'd1);
        idleCycle();

        // A stop on the expiry tick, and stop together with snooze while ringing.
        secV = 6'd0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, "ring5", 1'b1, 1'b1, 1'b0, 2'd0);
        idleCycle();
        secV = 6'd1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "snooze5", 1'b0, 1'b0, 1'b1, 2'd1);
        runTicks(299);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, "stopAtExpiry", 1'b0, 1'b0, 1'b0, 2'd1);
        idleCycle();
        secV = 6'd0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, "ring6", 1'b1, 1'b1, 1'b0, 2'd0);
        idleCycle();
        secV = 6'd1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "snooze6", 1'b0, 1'b0, 1'b1, 2'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "snoozeIgnored", 1'b0, 1'b0, 1'b1, 2'd1);
        runTicks(299);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, "reRing6", 1'b1, 1'b1, 1'b0, 2'd1);
        idleCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, "stopBeatsSnooze", 1'b0, 1'b0, 1'b0, 2'd1);
        idleCycle();

        // Asynchronous reset between clock edges while snoozing, then a midnight alarm.
        secV = 6'd0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, "ring7", 1'b1, 1'b1, 1'b0, 2'd0);
        idleCycle();
        secV = 6'd1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "snooze7", 1'b0, 1'b0, 1'b1, 2'd1);
        runTicks(5);
        idleCycle();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncReset", '{1'b0, 1'b0, 1'b0, 2'd0});
        #4;
        rst = 1'b0;
        bus.a_hour = 6'd0;
        bus.a_min  = 6'd0;
        hourV = 6'd0;
        minV  = 6'd0;
        secV  = 6'd0;
        idleCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, "midnight", 1'b1, 1'b1, 1'b0, 2'd0);
        secV = 6'd1;
        idleCycle();
        idleCycle();

        for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (expQ.size() > 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d expectations still queued, expected 0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
